prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Stream-fed writer for the single-cycle CPU's instruction and data memories.
//  Accepts a word stream of segment headers and payload words.
//  Drives IM/DM write ports so programs and data are loaded in hardware, not by bench pokes.
//  Holds the CPU in reset while loading and releases it when the end-of-program header arrives.
// PARAMETERS
//  ADDR_W  8   word-address width of IM and DM (depth 2**ADDR_W words)
//  DATA_W  32  memory word width; also the stream word width
// PORTS
//  clock        in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  in_valid     in   1       stream word valid
//  in_data      in   DATA_W  stream word (header or payload)
//  in_ready     out  1       loader can accept in_data this cycle
//  load_req     in   1       restart loading; honoured only in DONE
//  im_we        out  1       instruction-memory write strobe
//  im_addr      out  ADDR_W  instruction-memory word address
//  im_wdata     out  DATA_W  instruction-memory write data
//  dm_we        out  1       data-memory write strobe
//  dm_addr      out  ADDR_W  data-memory word address
//  dm_wdata     out  DATA_W  data-memory write data
//  cpu_reset_n  out  1       active-low reset to the CPU; high means CPU runs
//  busy         out  1       high in the HDR or DATA state
//  ovf          out  1       sticky: a segment's address wrapped past 2**ADDR_W-1
// BEHAVIOUR
//  Handshake: a word transfers on a rising edge where in_valid && in_ready. No other transfer exists.
//  Header fields:
//   [31]     sel: 0 = IM, 1 = DM
//   [23:16]  cnt: number of payload words
//   [ADDR_W-1:0]  base word address
//   All other bits are ignored.
//  cnt == 0 marks end-of-program. sel and base are ignored for it.
//  FSM states: HDR, DATA, DONE. Reset enters HDR.
//   HDR: in_ready = 1.
//    - Header accepted with cnt != 0: latch sel, base and cnt, then go to DATA.
//    - Header accepted with cnt == 0: go to DONE.
//   DATA: in_ready = 1.
//    - Each accepted word is written to the selected memory at the current address.
//    - After each write, the address increments and the remaining count decrements.
//    - On the cnt-th word, return to HDR.
//   DONE: in_ready = 0.
//    - load_req == 1: go to HDR and clear ovf.
//  Write latency: a word accepted at edge N gives a we pulse for exactly the cycle after edge N.
//   addr and wdata are registered and valid while we is high.
//   Only one of im_we or dm_we is ever high in a cycle.
//  Back-pressure: in_valid low in DATA stalls the segment. No write occurs and the count holds.
//  Address wrap: the address counter is ADDR_W bits and wraps modulo 2**ADDR_W.
//   The increment that wraps sets ovf. The write at the wrapped address still occurs.
//  cpu_reset_n:
//   - Low from reset and throughout HDR and DATA.
//   - Goes high on the edge after the end header is accepted.
//   - Goes low on the edge that accepts load_req.
//  Reset values (reset asserted at any time, including mid-segment):
//   - State returns to HDR and the count is discarded.
//   - Outputs: im_we=0, dm_we=0, addrs=0, wdata=0, cpu_reset_n=0, ovf=0, busy=1, in_ready=1.
//  Simultaneous events: load_req outside DONE is ignored.
//   The final payload word of a segment and the next header cannot coincide; they are one word per edge.
// STRUCTURE
//  loader_pkg holds:
//   - header field localparams: SEL_BIT=31, CNT_HI=23, CNT_LO=16
//   - state encodings: ST_HDR, ST_DATA, ST_DONE
//  Sub-module loader_addr_cnt covers the address counter and ovf:
//   - ADDR_W-bit loadable up-counter
//   - inputs: load, base, inc
//   - outputs: addr, wrap pulse
//  The FSM, remaining-count register and output registers stay in prog_loader.
// TESTING
//  1. IM load: header 0x00080000, then 8 words 0x20010000 .. 0xac020004 ->
//     8 im_we pulses at im_addr 0..7 with matching data; dm_we stays 0.
//  2. DM load: header 0x80010000, then word 1000 -> one dm_we pulse, dm_addr=0, dm_wdata=0x000003E8.
//     Then end header 0x00000000 -> cpu_reset_n=1 one edge later and in_ready=0.
//     Full system check: loop program runs and DM[1]=500500.
//  3. Back-pressure: in_valid low for 3 cycles mid-segment -> no we pulses during the stall.
//     Remaining words land at consecutive addresses and the total write count equals cnt.
//  4. Wrap: header 0x00040000 | 0xFE, then 4 words -> im_addr FE, FF, 00, 01; ovf=1 after the FF->00 step.
//  5. Reset mid-operation: reset low after 3 of 8 words -> all outputs at reset values immediately.
//     A new header is accepted after release.
//  6. Restart: in DONE, pulse load_req -> cpu_reset_n=0, ovf=0, in_ready=1 on the next cycle.
//     load_req while in DATA has no effect.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared header field positions and FSM state encoding for the program loader.
package loader_pkg;

  localparam int unsigned SEL_BIT = 31;
  localparam int unsigned CNT_HI  = 23;
  localparam int unsigned CNT_LO  = 16;
  localparam int unsigned CNT_W   = CNT_HI - CNT_LO + 1;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/loader_addr_cnt.sv
// Loadable word-address up-counter; flags the increment that wraps past all-ones.
module loader_addr_cnt #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              wrap_c_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o   = addr_q;
  assign wrap_c_o = inc_i && !load_i && (addr_q == '1);

endmodule

// File: rtl/prog_loader.sv
// Stream-fed IM/DM writer: parses segment headers, writes payload words and
// holds the CPU in reset until the end-of-program header arrives.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              ovf
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              sel_q, sel_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [DATA_W-1:0] im_wdata_q, im_wdata_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic              ovf_q, ovf_d;

  logic              accept_c;
  logic              hdr_load_c;
  logic              data_acc_c;
  logic [CNT_W-1:0]  hdr_cnt_c;
  logic [ADDR_W-1:0] hdr_base_c;
  logic [ADDR_W-1:0] cur_addr;
  logic              wrap_c;

  assign accept_c   = in_valid && in_ready_q;
  assign hdr_cnt_c  = in_data[CNT_HI:CNT_LO];
  assign hdr_base_c = in_data[ADDR_W-1:0];
  assign hdr_load_c = accept_c && (state_q == ST_HDR) && (hdr_cnt_c != '0);
  assign data_acc_c = accept_c && (state_q == ST_DATA);

  loader_addr_cnt #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clock    (clock),
    .reset    (reset),
    .load_i   (hdr_load_c),
    .base_i   (hdr_base_c),
    .inc_i    (data_acc_c),
    .addr_o   (cur_addr),
    .wrap_c_o (wrap_c)
  );

  // Next-state and next-output logic; write strobes default low so each is a one-cycle pulse.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sel_d      = sel_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    ovf_d      = ovf_q | wrap_c;

    case (state_q)
      ST_HDR: begin
        if (accept_c) begin
          if (hdr_cnt_c == '0) begin
            state_d = ST_DONE;
          end else begin
            sel_d   = in_data[SEL_BIT];
            rem_d   = hdr_cnt_c;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          if (sel_q) begin
            dm_we_d    = 1'b1;
            dm_addr_d  = cur_addr;
            dm_wdata_d = in_data;
          end else begin
            im_we_d    = 1'b1;
            im_addr_d  = cur_addr;
            im_wdata_d = in_data;
          end
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_HDR;
          end
        end
      end
      ST_DONE: begin
        if (load_req) begin
          state_d = ST_HDR;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase

    in_ready_d = (state_d != ST_DONE);
    busy_d     = (state_d != ST_DONE);
    cpu_run_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HDR;
      rem_q      <= '0;
      sel_q      <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b1;
      in_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      sel_q      <= sel_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      cpu_run_q  <= cpu_run_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign im_we       = im_we_q;
  assign im_addr     = im_addr_q;
  assign im_wdata    = im_wdata_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign cpu_reset_n = cpu_run_q;
  assign busy        = busy_q;
  assign ovf         = ovf_q;

endmodule
